l1_tag_ctrl: RTL and testbench
==============================

Name: l1_tag_ctrl

Overview:
Controller and initiator for the 256 x 19 dual-port L1 tag SRAM macro: one write port (csb0/addr0/din0) and one read port (csb1/addr1, dout1).
- Clears the array after reset and on flush, since the macro has no reset.
- Serves tag lookups through a valid/ready request/response pipeline and accepts fill/invalidate writes.
- Guarantees the macro never sees a same-address read and write in one cycle.
- Sits between the L1 cache FSM and the tag SRAM instance. The SRAM's clk0 and clk1 are tied to clk at the parent.

Parameters:
- TAG_WIDTH, 18, stored tag bits.
- INDEX_WIDTH, 8, set index bits (array depth = 1 << INDEX_WIDTH).
- ENTRY_WIDTH, TAG_WIDTH+1, SRAM word. Bit TAG_WIDTH is the valid bit; bits [TAG_WIDTH-1:0] are the tag.

Ports:
- clk  in  1  single clock (also drives SRAM clk0/clk1).
- rst_n  in  1  asynchronous active-low reset.
- lk_valid  in  1  lookup request valid.
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready.
- lk_index  in  INDEX_WIDTH  lookup set index.
- lk_tag  in  TAG_WIDTH  lookup compare tag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_hit  out  1  stored entry valid and tags equal.
- rsp_entry_valid  out  1  stored valid bit.
- rsp_tag  out  TAG_WIDTH  stored tag.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_index  in  INDEX_WIDTH  write set index.
- wr_tag  in  TAG_WIDTH  write tag.
- wr_set_valid  in  1  1 = fill, 0 = invalidate.
- flush  in  1  level-sampled; in RUN starts a full clear.
- busy  out  1  high when state != RUN.
- sram_csb0  out  1  write-port chip select, active low.
- sram_addr0  out  INDEX_WIDTH  write address.
- sram_din0  out  ENTRY_WIDTH  write data.
- sram_csb1  out  1  read-port chip select, active low.
- sram_addr1  out  INDEX_WIDTH  read address.
- sram_dout1  in  ENTRY_WIDTH  read data; valid at the posedge after issue.

Behaviour:
- FSM states and transitions:
  - RST: entered asynchronously on rst_n=0. Always moves to INIT at the next edge.
  - INIT: 8-bit sweep counter runs 0..255. Moves to RUN after writing entry 255.
  - RUN: normal operation. flush=1 in RUN moves to INIT with the counter cleared. flush in RST or INIT is ignored.
- Reset values: all flags, counter and response registers 0; rsp_valid=0, lk_ready=0, wr_ready=0, busy=1.
- While rst_n=0 or in RST: sram_csb0=sram_csb1=1, addresses 0, din0 0.
- INIT drives each cycle: csb0=0, addr0=counter, din0=0, csb1=1.
- All SRAM controls are combinational from the current state and the accepted requests; the macro registers them at posedge.
- Write path:
  - wr_ready = RUN && !flush.
  - An accepted write drives csb0=0, addr0=wr_index, din0={wr_set_valid, wr_tag} in that cycle.
  - One write per cycle; writes have no response.
- Lookup readiness: lk_ready = RUN && !flush && !skid_valid && !(inflight && rsp_valid && !rsp_ready). This is combinational from rsp_ready.
- Lookup issue:
  - An accepted lookup drives csb1=0, addr1=lk_index.
  - It registers inflight=1 with lk_tag.
- Response capture:
  - At the next edge, the entry (sram_dout1 or forwarded data) is captured into the rsp register, or into the 1-entry skid buffer if rsp is held and not popped.
  - Latency: response visible the cycle after the acceptance edge.
  - Order is strictly preserved. Response outputs hold stable while rsp_valid && !rsp_ready.
  - On pop, the skid buffer moves into rsp.
- Collision (lookup and write accepted in the same cycle, lk_index == wr_index):
  - csb1 is held 1 (read suppressed).
  - The entry is forwarded from {wr_set_valid, wr_tag}.
- A write one cycle before a read of the same index needs no forwarding: the macro commits on the negedge.
- A flush with lookups inflight or buffered: those responses still complete from the pre-clear data.
- Response fields:
  - rsp_hit = entry[TAG_WIDTH] && entry tag == captured lk_tag.
  - rsp_entry_valid = entry[TAG_WIDTH].
  - rsp_tag = entry tag.

Optional Feature:
- Macro: L1_TAG_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lookups[31:0] and perf_hits[31:0].
  - perf_lookups increments on each response pop; perf_hits increments on each pop with rsp_hit=1.
  - Both saturate at 0xFFFFFFFF and clear on reset and on entry to INIT.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Test Plan:
1. Release reset, hold lk_valid -> busy=1 for 257 cycles; addr0 steps 0..255 with din0=0 and csb1=1. Then lookup idx 0x05 tag 0x01234 -> rsp_hit=0, rsp_entry_valid=0 one cycle after acceptance.
2. Fill idx 0x10 tag 0x2ABCD, then lookup idx 0x10 tag 0x2ABCD next cycle -> rsp_hit=1, rsp_tag=0x2ABCD. Lookup tag 0x2ABCE -> rsp_hit=0, rsp_entry_valid=1.
3. Same-cycle fill and lookup, idx 0x20 tag 0x00055 -> sram_csb1=1 that cycle, rsp_hit=1 via forwarding.
4. rsp_ready=0 with 3 back-to-back lookups (idx 1, 2, 3) -> only 2 accepted and lk_ready drops. Raise rsp_ready -> responses for idx 1 then 2, each held stable until popped.
5. After filling idx 0x10, pulse flush in RUN -> busy for 256 cycles, wr_ready=lk_ready=0. Then lookup idx 0x10 -> rsp_hit=0.
6. Assert rst_n=0 at INIT counter 100 -> sram_csb0=1 immediately. After release: RST then INIT restarting at addr0=0.

Source files
------------

// File: rtl/l1_tag_ctrl.sv
// Tag-SRAM controller for the L1 cache: post-reset/flush clear sweep, lookup pipeline with skid buffer, write port arbitration.
// Optional performance counters are enabled by defining L1_TAG_PERF_CNT_EN.
module l1_tag_ctrl #(
    parameter int TAG_WIDTH   = 18,
    parameter int INDEX_WIDTH = 8,
    parameter int ENTRY_WIDTH = TAG_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lk_valid,
    output logic                   lk_ready,
    input  logic [INDEX_WIDTH-1:0] lk_index,
    input  logic [TAG_WIDTH-1:0]   lk_tag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_hit,
    output logic                   rsp_entry_valid,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic                   wr_set_valid,
    input  logic                   flush,
    output logic                   busy,
    output logic                   sram_csb0,
    output logic [INDEX_WIDTH-1:0] sram_addr0,
    output logic [ENTRY_WIDTH-1:0] sram_din0,
    output logic                   sram_csb1,
    output logic [INDEX_WIDTH-1:0] sram_addr1,
    input  logic [ENTRY_WIDTH-1:0] sram_dout1
`ifdef L1_TAG_PERF_CNT_EN
    ,
    output logic [31:0]            perf_lookups,
    output logic [31:0]            perf_hits
`endif
);

    localparam int RSP_W = ENTRY_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] CNT_LAST = {INDEX_WIDTH{1'b1}};
    localparam logic [INDEX_WIDTH-1:0] CNT_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;

    logic                   inflight_q, inflight_d;
    logic [TAG_WIDTH-1:0]   lk_tag_q, lk_tag_d;
    logic                   fwd_q, fwd_d;
    logic [ENTRY_WIDTH-1:0] fwd_entry_q, fwd_entry_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]       rsp_q, rsp_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [RSP_W-1:0]       skid_q, skid_d;

    logic                   run_s;
    logic                   lk_ready_s;
    logic                   wr_ready_s;
    logic                   lk_fire_s;
    logic                   wr_fire_s;
    logic                   collide_s;
    logic                   pop_s;
    logic [ENTRY_WIDTH-1:0] entry_s;
    logic                   hit_s;

    assign run_s      = (state_q == ST_RUN);
    assign wr_ready_s = run_s && !flush;
    // A new lookup is refused whenever its response would have nowhere to land.
    assign lk_ready_s = run_s && !flush && !skid_valid_q && !(inflight_q && rsp_valid_q && !rsp_ready);
    assign lk_fire_s  = lk_valid && lk_ready_s;
    assign wr_fire_s  = wr_valid && wr_ready_s;
    assign collide_s  = lk_fire_s && wr_fire_s && (lk_index == wr_index);
    assign pop_s      = rsp_valid_q && rsp_ready;

    assign entry_s = fwd_q ? fwd_entry_q : sram_dout1;
    assign hit_s   = entry_s[TAG_WIDTH] && (entry_s[TAG_WIDTH-1:0] == lk_tag_q);

    // FSM state and sweep counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
            ST_INIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: handshakes, busy and SRAM port controls
    always_comb begin
        busy       = 1'b1;
        lk_ready   = 1'b0;
        wr_ready   = 1'b0;
        sram_csb0  = 1'b1;
        sram_addr0 = '0;
        sram_din0  = '0;
        sram_csb1  = 1'b1;
        sram_addr1 = '0;
        case (state_q)
            ST_INIT: begin
                sram_csb0  = 1'b0;
                sram_addr0 = cnt_q;
            end
            ST_RUN: begin
                busy     = 1'b0;
                lk_ready = lk_ready_s;
                wr_ready = wr_ready_s;
                if (wr_fire_s) begin
                    sram_csb0  = 1'b0;
                    sram_addr0 = wr_index;
                    sram_din0  = {wr_set_valid, wr_tag};
                end else begin
                    sram_csb0  = 1'b1;
                end
                // A same-index write in this cycle is forwarded instead of read.
                if (lk_fire_s && !collide_s) begin
                    sram_csb1  = 1'b0;
                    sram_addr1 = lk_index;
                end else begin
                    sram_csb1  = 1'b1;
                end
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Lookup pipeline, response register and skid buffer next-state
    always_comb begin
        inflight_d   = lk_fire_s;
        lk_tag_d     = lk_fire_s ? lk_tag : lk_tag_q;
        fwd_d        = collide_s;
        fwd_entry_d  = collide_s ? {wr_set_valid, wr_tag} : fwd_entry_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_d        = rsp_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (pop_s) begin
            if (skid_valid_q) begin
                rsp_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (inflight_q) begin
                rsp_d = {hit_s, entry_s};
            end else begin
                rsp_valid_d = 1'b0;
            end
        end else if (!rsp_valid_q) begin
            if (inflight_q) begin
                rsp_valid_d = 1'b1;
                rsp_d       = {hit_s, entry_s};
            end else begin
                rsp_valid_d = 1'b0;
            end
        end else begin
            if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_d       = {hit_s, entry_s};
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Lookup pipeline, response register and skid buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q   <= 1'b0;
            lk_tag_q     <= '0;
            fwd_q        <= 1'b0;
            fwd_entry_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            inflight_q   <= inflight_d;
            lk_tag_q     <= lk_tag_d;
            fwd_q        <= fwd_d;
            fwd_entry_q  <= fwd_entry_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_q        <= rsp_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_hit         = rsp_q[RSP_W-1];
    assign rsp_entry_valid = rsp_q[TAG_WIDTH];
    assign rsp_tag         = rsp_q[TAG_WIDTH-1:0];

`ifdef L1_TAG_PERF_CNT_EN
    logic [31:0] perf_lookups_q;
    logic [31:0] perf_hits_q;
    logic        init_entry_s;

    assign init_entry_s = (state_d == ST_INIT) && (state_q != ST_INIT);

    // Saturating pop/hit counters, cleared whenever a clear sweep starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lookups_q <= 32'd0;
            perf_hits_q    <= 32'd0;
        end else if (init_entry_s) begin
            perf_lookups_q <= 32'd0;
            perf_hits_q    <= 32'd0;
        end else begin
            if (pop_s && (perf_lookups_q != 32'hFFFF_FFFF)) begin
                perf_lookups_q <= perf_lookups_q + 32'd1;
            end
            if (pop_s && rsp_q[RSP_W-1] && (perf_hits_q != 32'hFFFF_FFFF)) begin
                perf_hits_q <= perf_hits_q + 32'd1;
            end
        end
    end

    assign perf_lookups = perf_lookups_q;
    assign perf_hits    = perf_hits_q;
`endif

endmodule

// File: tb/tb_l1_tag_ctrl.sv
// Bench for l1_tag_ctrl: behavioural SRAM, array reference model and response scoreboard.
module tb_l1_tag_ctrl;

    localparam int TW = 18;
    localparam int IW = 8;
    localparam int EW = TW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lk_valid, lk_ready;
    logic [IW-1:0] lk_index;
    logic [TW-1:0] lk_tag;
    logic          rsp_valid, rsp_ready, rsp_hit, rsp_entry_valid;
    logic [TW-1:0] rsp_tag;
    logic          wr_valid, wr_ready, wr_set_valid;
    logic [IW-1:0] wr_index;
    logic [TW-1:0] wr_tag;
    logic          flush, busy;
    logic          sram_csb0, sram_csb1;
    logic [IW-1:0] sram_addr0, sram_addr1;
    logic [EW-1:0] sram_din0, sram_dout1;
`ifdef L1_TAG_PERF_CNT_EN
    logic [31:0]   perf_lookups, perf_hits;
`endif

    always #5 clk = ~clk;

    l1_tag_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index), .lk_tag(lk_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_entry_valid(rsp_entry_valid), .rsp_tag(rsp_tag),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_tag(wr_tag),
        .wr_set_valid(wr_set_valid), .flush(flush), .busy(busy),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef L1_TAG_PERF_CNT_EN
        , .perf_lookups(perf_lookups), .perf_hits(perf_hits)
`endif
    );

    // Behavioural tag macro: ports latched at posedge, committed at the following negedge
    logic [EW-1:0] mem [256];
    logic          csb0_l = 1'b1, csb1_l = 1'b1;
    logic [IW-1:0] a0_l, a1_l;
    logic [EW-1:0] d0_l;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = EW'($urandom);
        sram_dout1 = EW'($urandom);
    end

    always @(posedge clk) begin
        csb0_l <= sram_csb0;
        csb1_l <= sram_csb1;
        a0_l   <= sram_addr0;
        a1_l   <= sram_addr1;
        d0_l   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!csb0_l) mem[a0_l] <= d0_l;
        if (!csb1_l) sram_dout1 <= mem[a1_l];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the array contents as seen by the cache, plus expected responses in order
    typedef struct packed {
        logic          hit;
        logic          vld;
        logic [TW-1:0] tag;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [EW-1:0] ref_mem [256];
    logic          held = 1'b0;
    rsp_t          held_val;

    initial for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    always @(negedge clk) begin
        rsp_t          cur, e;
        logic [EW-1:0] ent;
        cur = {rsp_hit, rsp_entry_valid, rsp_tag};
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            held = 1'b0;
        end else begin
            if (!sram_csb0 && !sram_csb1) chk("rw_same_addr", 64'(sram_addr0 != sram_addr1), 64'd1);
            if (held) begin
                chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                chk("rsp_hold_data", 64'(cur), 64'(held_val));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got 0x%0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 64'(cur), 64'(e));
                end
            end
            held     = rsp_valid && !rsp_ready;
            held_val = cur;
            if (wr_valid && wr_ready) ref_mem[wr_index] = {wr_set_valid, wr_tag};
            if (lk_valid && lk_ready) begin
                ent   = ref_mem[lk_index];
                e.vld = ent[TW];
                e.tag = ent[TW-1:0];
                e.hit = ent[TW] && (ent[TW-1:0] == lk_tag);
                exp_q.push_back(e);
            end
            if (flush && !busy) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || rsp_valid); i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        logic ok;
        ok       = 1'b0;
        lk_valid = 1'b1;
        lk_index = idx;
        lk_tag   = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = lk_ready;
            tick();
        end
        lk_valid = 1'b0;
        chk("lk_accept", 64'(ok), 64'd1);
    endtask

    task automatic write(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic sv);
        logic ok;
        ok           = 1'b0;
        wr_valid     = 1'b1;
        wr_index     = idx;
        wr_tag       = tag;
        wr_set_valid = sv;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        chk("wr_accept", 64'(ok), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_cnt, bad, exp_addr;
        logic acc;
        rst_n = 1'b0; lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
        wr_valid = 1'b0; wr_index = '0; wr_tag = '0; wr_set_valid = 1'b0;
        flush = 1'b0; rsp_ready = 1'b1;
        repeat (3) tick();

        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_lk_ready", 64'(lk_ready), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_csb", 64'({sram_csb0, sram_csb1}), 64'd3);
        chk("rst_addr_din", 64'({sram_addr0, sram_addr1, sram_din0}), 64'd0);

        // Clear sweep after reset, lookup held pending until RUN
        lk_valid = 1'b1; lk_index = 8'h05; lk_tag = 18'h01234;
        rst_n = 1'b1;
        busy_cnt = 0; bad = 0; exp_addr = 0; acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (busy_cnt == 1) begin
                    if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) bad++;
                end else begin
                    if (sram_csb0 !== 1'b0 || sram_addr0 !== 8'(exp_addr) || sram_din0 !== '0 ||
                        sram_csb1 !== 1'b1 || lk_ready !== 1'b0 || wr_ready !== 1'b0) bad++;
                    exp_addr++;
                end
            end else begin
                acc = lk_ready;
            end
            tick();
        end
        lk_valid = 1'b0;
        chk("init_busy_cycles", 64'(busy_cnt), 64'd257);
        chk("init_sweep_errors", 64'(bad), 64'd0);
        chk("init_lookup_accept", 64'(acc), 64'd1);
        drain();

        // Fill then read back: hit, then tag mismatch on a valid entry
        write(8'h10, 18'h2ABCD, 1'b1);
        lookup(8'h10, 18'h2ABCD);
        lookup(8'h10, 18'h2ABCE);
        drain();

        // Same-cycle fill and lookup on one index
        lk_valid = 1'b1; lk_index = 8'h20; lk_tag = 18'h00055;
        wr_valid = 1'b1; wr_index = 8'h20; wr_tag = 18'h00055; wr_set_valid = 1'b1;
        @(negedge clk);
        chk("collide_handshake", 64'({lk_ready, wr_ready}), 64'd3);
        chk("collide_csb1", 64'(sram_csb1), 64'd1);
        chk("collide_csb0", 64'(sram_csb0), 64'd0);
        tick();
        lk_valid = 1'b0; wr_valid = 1'b0;
        drain();

        // Back-pressure: two lookups absorbed, third refused
        rsp_ready = 1'b0;
        lk_valid = 1'b1; lk_index = 8'h01; lk_tag = 18'h0;
        @(negedge clk); chk("bp_accept1", 64'(lk_ready), 64'd1); tick();
        lk_index = 8'h02;
        @(negedge clk); chk("bp_accept2", 64'(lk_ready), 64'd1); tick();
        lk_index = 8'h03;
        @(negedge clk); chk("bp_ready_drop", 64'(lk_ready), 64'd0); tick();
        @(negedge clk); chk("bp_ready_skid", 64'(lk_ready), 64'd0); tick();
        lk_valid = 1'b0;
        repeat (3) tick();
        chk("bp_rsp_pending", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        drain();

        // Flush with a lookup still in flight, then lookup after the clear
        write(8'h10, 18'h2ABCD, 1'b1);
        lookup(8'h10, 18'h2ABCD);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'({lk_ready, wr_ready}), 64'd0);
        tick();
        flush = 1'b0;
        lk_valid = 1'b1; lk_index = 8'h10; lk_tag = 18'h2ABCD;
        busy_cnt = 0; bad = 0; acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (lk_ready !== 1'b0 || wr_ready !== 1'b0) bad++;
            end else begin
                acc = lk_ready;
            end
            tick();
        end
        lk_valid = 1'b0;
        chk("flush_busy_cycles", 64'(busy_cnt), 64'd256);
        chk("flush_ready_errors", 64'(bad), 64'd0);
        chk("flush_lookup_accept", 64'(acc), 64'd1);
        drain();

        // Reset in the middle of a clear sweep
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 400 && !(busy && !sram_csb0 && sram_addr0 == 8'd100); i++) tick();
        chk("sweep_reach_100", 64'(sram_addr0), 64'd100);
        rst_n = 1'b0;
        #1;
        chk("rst_async_csb0", 64'(sram_csb0), 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_state_csb0", 64'(sram_csb0), 64'd1);
        chk("rst_state_busy", 64'(busy), 64'd1);
        tick();
        chk("reinit_addr0", 64'({sram_csb0, sram_addr0}), 64'd0);
        tick();
        chk("reinit_addr1", 64'({sram_csb0, sram_addr0}), 64'd1);
        for (int i = 0; i < 400 && busy; i++) tick();
        chk("reinit_done", 64'(busy), 64'd0);

        // Randomized traffic over a small index/tag space to exercise collisions and back-pressure
        for (int i = 0; i < 3000; i++) begin
            lk_valid     = ($urandom % 3) != 0;
            lk_index     = 8'($urandom_range(0, 7));
            lk_tag       = 18'($urandom_range(0, 3));
            wr_valid     = ($urandom % 3) == 0;
            wr_index     = 8'($urandom_range(0, 7));
            wr_tag       = 18'($urandom_range(0, 3));
            wr_set_valid = ($urandom % 4) != 0;
            rsp_ready    = ($urandom % 4) != 0;
            flush        = ($urandom % 1000) == 0;
            tick();
        end
        lk_valid = 1'b0; wr_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
